hazard_unit_mc: RTL
===================

# hazard_unit_mc

Parametrised pipeline hazard unit for the riscv_32M core, placed in the ID stage. It combines the existing load-use check against the ID/EX register with a register scoreboard for multi-cycle M-extension operations. Those operations may be issued pipelined and may complete out of order. The unit produces a single stall (hold PC and IF/ID, inject an ID/EX bubble), per-cause flags, a saturating stall-cycle counter and a sticky protocol-error flag.

## Interface
- NUM_REGS, 32, architectural register count; register 0 is hard-wired zero.
- REG_ID_W, $clog2(NUM_REGS), register-index width.
- MAX_OUTSTANDING, 4, maximum in-flight long ops (range 1..NUM_REGS-1).
- STALL_CNT_W, 16, stall counter width.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_rs1, id_rs2  in  REG_ID_W  ID source indices
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd  in  REG_ID_W  ID destination index
- id_writes_rd  in  1  ID instruction writes rd
- id_is_long  in  1  ID instruction is multi-cycle (mul/div)
- ex_valid  in  1  ID/EX register valid
- ex_rd  in  REG_ID_W  ID/EX destination
- ex_mem_read  in  1  ID/EX instruction is a load
- flush  in  1  ID instruction squashed this cycle (branch redirect)
- lu_done  in  1  long unit writes back this cycle
- lu_rd  in  REG_ID_W  long-unit writeback destination
- stall  out  1  hold IF/PC and IF/ID, bubble into ID/EX
- stall_cause  out  4  [0] load-use, [1] scoreboard RAW, [2] scoreboard WAW, [3] structural
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight long ops
- stall_cycles  out  STALL_CNT_W  saturating count of stalled cycles
- err_spurious  out  1  sticky: lu_done for a register that is not pending

## Operation
- State: pending[NUM_REGS-1:1] (bit 0 is constant 0), outstanding counter, stall_cycles, err_spurious.
- Register 0 never causes a hazard and is never marked pending.
- Load-use: id_valid & ex_valid & ex_mem_read & ex_rd≠0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- RAW: id_valid & a used source has its registered pending bit set. There is no bypass from a same-cycle lu_done.
- WAW: id_valid & id_writes_rd & id_rd≠0 & pending[id_rd]. This applies to any writer, long or short, and prevents out-of-order overwrite.
- Structural: id_valid & id_is_long & outstanding==MAX_OUTSTANDING (registered value).
- stall_cause bits are all evaluated independently; several may be set at once. When flush=1, all four bits and stall are forced to 0.
- stall = |stall_cause.
- issue = id_valid & id_is_long & ~stall & ~flush.
  - Sets pending[id_rd] when id_writes_rd & id_rd≠0.
  - Increments outstanding whenever it fires, including when rd is x0.
- Completion on lu_done:
  - If lu_rd≠0 and pending[lu_rd]: clear the bit and decrement outstanding.
  - If lu_rd==0: decrement outstanding only. This is the result of an x0-destination op.
  - If lu_rd≠0 and the bit is clear: set err_spurious; pending and outstanding are unchanged.
- lu_done with outstanding==0: set err_spurious; no state change.
- Simultaneous issue and lu_done: outstanding is unchanged net. The two registers cannot be the same because WAW blocks issue to a pending register.
- flush does not cancel in-flight long ops; they are older than the redirect and complete normally.
- stall_cycles increments on every cycle with stall=1 and saturates at all-ones.

## Timing
- Reset values: pending=0, outstanding=0, stall_cycles=0, err_spurious=0. Consequently stall and stall_cause are 0 whenever the ID/EX inputs are idle.
- stall and stall_cause are combinational from inputs and registered state, and are valid in the same cycle.
- Pending set and clear take effect at the next rising clk edge. An instruction stalled on RAW therefore releases the cycle after lu_done.
- Load-use costs exactly one bubble cycle, since ex_valid drops once the bubble enters.
- Reset asserted mid-operation clears all state immediately (asynchronously). lu_done values that arrive after reset for pre-reset ops set err_spurious.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, rs2_used=1 -> stall=1, cause=4'b0001, for one cycle; stall_cycles=1. Same with rd=0 -> stall=0.
- RAW: issue long op with rd=7, then ID reads x7 -> stall while pending. lu_done with lu_rd=7 -> stall drops the following cycle; outstanding goes 1->0.
- WAW: long rd=9 pending, short ALU op writes x9 -> cause=4'b0100. After completion the op proceeds.
- Structural: MAX_OUTSTANDING=2; issue rd=3, then rd=4; third long op -> cause=4'b1000. lu_done rd=4 -> issues the next cycle; pending{3,new}.
- Flush priority: RAW condition present with flush=1 -> stall=0, no issue, outstanding unchanged.
- Errors and reset: lu_done rd=12 not pending -> err_spurious=1 and stays set. Assert reset with 3 ops outstanding -> all outputs 0 immediately.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// ID-stage hazard unit: load-use check plus a register scoreboard for pipelined,
// out-of-order completing multi-cycle (mul/div) operations.
module hazard_unit_mc #(
    parameter int unsigned NUM_REGS        = 32,
    parameter int unsigned REG_ID_W        = $clog2(NUM_REGS),
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STALL_CNT_W     = 16,
    localparam int unsigned OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [REG_ID_W-1:0]    id_rs1,
    input  logic [REG_ID_W-1:0]    id_rs2,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic [REG_ID_W-1:0]    id_rd,
    input  logic                   id_writes_rd,
    input  logic                   id_is_long,
    input  logic                   ex_valid,
    input  logic [REG_ID_W-1:0]    ex_rd,
    input  logic                   ex_mem_read,
    input  logic                   flush,
    input  logic                   lu_done,
    input  logic [REG_ID_W-1:0]    lu_rd,
    output logic                   stall,
    output logic [3:0]             stall_cause,
    output logic [OUT_W-1:0]       outstanding,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   err_spurious
);

    logic [NUM_REGS-1:1]    pending_q, pending_d;
    logic [OUT_W-1:0]       outstanding_q, outstanding_d;
    logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic                   err_q, err_d;

    logic [NUM_REGS-1:0] pend_full, pend_next;
    logic load_use, raw, waw, structural, issue, lu_legal, lu_spur;

    // x0 reads as never pending
    assign pend_full = {pending_q, 1'b0};

    always_comb begin
        load_use   = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                     ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
        raw        = id_valid & ((id_rs1_used & pend_full[id_rs1]) |
                                 (id_rs2_used & pend_full[id_rs2]));
        waw        = id_valid & id_writes_rd & (id_rd != '0) & pend_full[id_rd];
        structural = id_valid & id_is_long & (outstanding_q == OUT_W'(MAX_OUTSTANDING));

        stall_cause = flush ? 4'b0000 : {structural, waw, raw, load_use};
        stall       = |stall_cause;
        issue       = id_valid & id_is_long & ~stall & ~flush;

        // A completion is legal only against a real in-flight op
        lu_legal = lu_done & (outstanding_q != '0) & ((lu_rd == '0) | pend_full[lu_rd]);
        lu_spur  = lu_done & ~lu_legal;
    end

    always_comb begin
        pend_next = pend_full;
        if (lu_legal && lu_rd != '0) pend_next[lu_rd] = 1'b0;
        if (issue && id_writes_rd && id_rd != '0) pend_next[id_rd] = 1'b1;
        pending_d = pend_next[NUM_REGS-1:1];

        outstanding_d = outstanding_q;
        unique case ({issue, lu_legal})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        stall_cycles_d = stall_cycles_q;
        if (stall && stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);

        err_d = err_q | lu_spur;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q      <= '0;
            outstanding_q  <= '0;
            stall_cycles_q <= '0;
            err_q          <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            outstanding_q  <= outstanding_d;
            stall_cycles_q <= stall_cycles_d;
            err_q          <= err_d;
        end
    end

    assign outstanding  = outstanding_q;
    assign stall_cycles = stall_cycles_q;
    assign err_spurious = err_q;

endmodule
